pe_mac_pipe: RTL and testbench

- Next-generation systolic processing element for the MHA matrix engine.
- Fully pipelined signed fixed-point multiply-accumulate. Accepts one operand pair per cycle with no bubbles.
- Forwards X right and W down one cycle later.
- Emits one rounded, range-checked D_W result per dot product, delimited by I_LAST.
- Generalised over data width, fraction bits, accumulator width and multiplier latency.

---
 rtl/pe_mac_pipe.sv | 113 +++++++++++
 tb/tb_pe_mac_pipe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_pipe.sv
// Systolic PE: pipelined signed fixed-point MAC with X/W forwarding and rounded dot-product output.
// Optional macro PE_MAC_SAT_EN: clamp out-of-range results instead of wrapping them.
module pe_mac_pipe #(
  parameter int unsigned D_W     = 16,
  parameter int unsigned FRAC_W  = 13,
  parameter int unsigned ACC_W   = 36,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic           I_CLK,
  input  logic           I_RST_N,
  input  logic           I_VLD,
  input  logic           I_LAST,
  input  logic [D_W-1:0] I_X,
  input  logic [D_W-1:0] I_W,
  output logic           O_X_VLD,
  output logic           O_X_LAST,
  output logic [D_W-1:0] O_X,
  output logic [D_W-1:0] O_W,
  output logic           O_VLD,
  output logic [D_W-1:0] O_D,
  output logic           O_OVF
);

  localparam int unsigned P_W = 2 * D_W;
  localparam int unsigned S_W = ACC_W + 1;
  localparam int unsigned R_W = S_W - FRAC_W;

  logic signed [P_W-1:0]   prod_q [MUL_LAT];
  logic [MUL_LAT-1:0]      pv_q;
  logic [MUL_LAT-1:0]      pl_q;
  logic signed [ACC_W-1:0] acc_q;
  logic                    first_q;

  logic signed [ACC_W-1:0] prod_ext_c;
  logic signed [ACC_W-1:0] acc_next_c;
  logic signed [S_W-1:0]   s_c;
  logic signed [R_W-1:0]   r_c;
  logic                    ovf_c;
  logic [D_W-1:0]          d_c;

  // Forwarding registers; they also serve as the operand register of the multiplier.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      O_X      <= '0;
      O_W      <= '0;
      O_X_VLD  <= 1'b0;
      O_X_LAST <= 1'b0;
    end else begin
      O_X_VLD  <= I_VLD;
      O_X_LAST <= I_VLD & I_LAST;
      if (I_VLD) begin
        O_X <= I_X;
        O_W <= I_W;
      end
    end
  end

  // Multiplier pipeline, product travels with its valid and last bits.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      pv_q <= '0;
      pl_q <= '0;
      for (int unsigned k = 0; k < MUL_LAT; k++) prod_q[k] <= '0;
    end else begin
      prod_q[0] <= $signed(O_X) * $signed(O_W);
      pv_q[0]   <= O_X_VLD;
      pl_q[0]   <= O_X_LAST;
      for (int unsigned k = 1; k < MUL_LAT; k++) begin
        prod_q[k] <= prod_q[k-1];
        pv_q[k]   <= pv_q[k-1];
        pl_q[k]   <= pl_q[k-1];
      end
    end
  end

  // Accumulate, round half toward +inf, range check.
  always_comb begin
    prod_ext_c = ACC_W'(prod_q[MUL_LAT-1]);
    acc_next_c = (first_q ? '0 : acc_q) + prod_ext_c;
    s_c        = S_W'(acc_next_c) + (S_W'(1) << (FRAC_W - 1));
    r_c        = R_W'(s_c >>> FRAC_W);
    // Fits in D_W iff all bits from the D_W-1 sign position upward agree.
    ovf_c      = (|r_c[R_W-1:D_W-1]) && !(&r_c[R_W-1:D_W-1]);
`ifdef PE_MAC_SAT_EN
    if (ovf_c) d_c = r_c[R_W-1] ? {1'b1, {(D_W-1){1'b0}}} : {1'b0, {(D_W-1){1'b1}}};
    else       d_c = r_c[D_W-1:0];
`else
    d_c        = r_c[D_W-1:0];
`endif
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      acc_q   <= '0;
      first_q <= 1'b1;
      O_VLD   <= 1'b0;
      O_D     <= '0;
      O_OVF   <= 1'b0;
    end else begin
      O_VLD <= 1'b0;
      if (pv_q[MUL_LAT-1]) begin
        acc_q   <= acc_next_c;
        first_q <= pl_q[MUL_LAT-1];
        if (pl_q[MUL_LAT-1]) begin
          O_VLD <= 1'b1;
          O_D   <= d_c;
          O_OVF <= ovf_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Self-checking bench for pe_mac_pipe: dot-product reference model plus directed literal cases.
module tb_pe_mac_pipe;
  localparam int unsigned D_W     = 16;
  localparam int unsigned FRAC_W  = 13;
  localparam int unsigned ACC_W   = 36;
  localparam int unsigned MUL_LAT = 2;

  logic           I_CLK = 1'b0;
  logic           I_RST_N;
  logic           I_VLD, I_LAST;
  logic [D_W-1:0] I_X, I_W;
  logic           O_X_VLD, O_X_LAST, O_VLD, O_OVF;
  logic [D_W-1:0] O_X, O_W, O_D;

  always #5 I_CLK = ~I_CLK;

  pe_mac_pipe #(.D_W(D_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W), .MUL_LAT(MUL_LAT)) dut (
    .I_CLK(I_CLK), .I_RST_N(I_RST_N), .I_VLD(I_VLD), .I_LAST(I_LAST),
    .I_X(I_X), .I_W(I_W), .O_X_VLD(O_X_VLD), .O_X_LAST(O_X_LAST),
    .O_X(O_X), .O_W(O_W), .O_VLD(O_VLD), .O_D(O_D), .O_OVF(O_OVF)
  );

  typedef struct {
    int             due;
    logic [D_W-1:0] d;
    bit             ovf;
  } res_t;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;
  int pulse_edges[$];

  // Reference model: running sum as plain integer, pending results scheduled by edge number.
  longint         m_acc;
  bit             m_first;
  res_t           pend[$];
  logic [D_W-1:0] ex_x, ex_w, ex_d;
  bit             ex_xv, ex_xl, ex_ovf;

  function automatic longint wrap_acc(longint v);
    return (v <<< (64 - ACC_W)) >>> (64 - ACC_W);
  endfunction

  function automatic void chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endfunction

  function automatic void model_clear();
    pend.delete();
    m_acc   = 0;
    m_first = 1'b1;
    ex_x = '0; ex_w = '0; ex_d = '0;
    ex_xv = 1'b0; ex_xl = 1'b0; ex_ovf = 1'b0;
  endfunction

  // One clock: drive at negedge and update the model, then compare all outputs after the edge.
  task automatic cycle(bit rst_n, bit v, bit l, logic [D_W-1:0] x, logic [D_W-1:0] w);
    longint s, r, maxv, minv;
    res_t   res;
    bit     exp_v;
    @(negedge I_CLK);
    I_RST_N = rst_n; I_VLD = v; I_LAST = l; I_X = x; I_W = w;
    if (!rst_n) begin
      model_clear();
    end else if (v) begin
      ex_x = x; ex_w = w; ex_xv = 1'b1; ex_xl = l;
      m_acc   = wrap_acc((m_first ? 64'sd0 : m_acc) + longint'($signed(x)) * longint'($signed(w)));
      m_first = l;
      if (l) begin
        maxv = (longint'(1) <<< (D_W - 1)) - 1;
        minv = -(longint'(1) <<< (D_W - 1));
        s = m_acc + (longint'(1) <<< (FRAC_W - 1));
        r = s >>> FRAC_W;
        res.ovf = (r > maxv) || (r < minv);
        res.d   = D_W'(r);
`ifdef PE_MAC_SAT_EN
        if (res.ovf) res.d = (r > 0) ? D_W'(maxv) : D_W'(minv);
`endif
        res.due = edge_cnt + 1 + MUL_LAT + 1;
        pend.push_back(res);
      end
    end else begin
      ex_xv = 1'b0; ex_xl = 1'b0;
    end
    @(posedge I_CLK);
    #2;
    edge_cnt++;
    exp_v = (pend.size() > 0) && (pend[0].due == edge_cnt);
    if (exp_v) begin
      ex_d   = pend[0].d;
      ex_ovf = pend[0].ovf;
      pend.delete(0);
    end
    chk("o_vld", O_VLD, exp_v);
    chk("o_d", O_D, ex_d);
    chk("o_ovf", O_OVF, ex_ovf);
    chk("o_x", O_X, ex_x);
    chk("o_w", O_W, ex_w);
    chk("o_x_vld", O_X_VLD, ex_xv);
    chk("o_x_last", O_X_LAST, ex_xl);
    if (O_VLD) pulse_edges.push_back(edge_cnt);
  endtask

  // Idle until a result pulse (bounded) and pin it to a hand-computed value.
  task automatic expect_pulse(string name, logic [D_W-1:0] d, bit ovf);
    bit found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0, '0, '0);
      if (O_VLD) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL %s: no result pulse within 10 cycles", name);
    end else begin
      chk({name, "_d"}, O_D, d);
      chk({name, "_ovf"}, O_OVF, ovf);
    end
  endtask

  task automatic reset_pulse();
    cycle(1'b0, 1'b0, 1'b0, '0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int gap;
    logic [D_W-1:0] ovf_d;
    I_RST_N = 1'b0; I_VLD = 1'b0; I_LAST = 1'b0; I_X = '0; I_W = '0;
    model_clear();

    // Reset values and idle.
    reset_pulse();
    repeat (5) cycle(1'b1, 1'b0, 1'b0, '0, '0);

    // Single-element dot products.
    cycle(1'b1, 1'b1, 1'b1, 16'h2000, 16'h2000);
    expect_pulse("single_pos", 16'h2000, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 16'hE000, 16'h2000);
    expect_pulse("single_neg", 16'hE000, 1'b0);

    // Back-to-back dot products with no gap.
    pulse_edges.delete();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, (i == 3), 16'h2000, 16'h1000);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, (i == 1), 16'h2000, 16'h2000);
    expect_pulse("b2b_first", 16'h4000, 1'b0);
    expect_pulse("b2b_second", 16'h4000, 1'b0);
    gap = (pulse_edges.size() >= 2) ? (pulse_edges[1] - pulse_edges[0]) : -1;
    chk("b2b_gap", gap, 2);

    // Rounding at the half-LSB boundary.
    cycle(1'b1, 1'b1, 1'b1, 16'h0001, 16'h1000);
    expect_pulse("round_up", 16'h0001, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 16'h0001, 16'h0FFF);
    expect_pulse("round_down", 16'h0000, 1'b0);

    // Overflow: 4 x 2.25 = 9.0.
`ifdef PE_MAC_SAT_EN
    ovf_d = 16'h7FFF;
`else
    ovf_d = 16'h2000;
`endif
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, (i == 3), 16'h3000, 16'h3000);
    expect_pulse("overflow", ovf_d, 1'b1);

    // Reset in the middle of a dot product discards the partial sum.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 16'h2000, 16'h2000);
    reset_pulse();
    cycle(1'b1, 1'b1, 1'b1, 16'h2000, 16'h2000);
    expect_pulse("after_reset", 16'h2000, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, '0, '0);

    // Idle cycles inside a dot product and ignored I_LAST without I_VLD.
    cycle(1'b1, 1'b1, 1'b0, 16'h2000, 16'h2000);
    cycle(1'b1, 1'b0, 1'b1, 16'h7FFF, 16'h7FFF);
    cycle(1'b1, 1'b1, 1'b1, 16'h2000, 16'hF000);
    expect_pulse("idle_gap", 16'h1000, 1'b0);

    // Randomized traffic with occasional resets, checked every cycle against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(199, 0) == 0) begin
        reset_pulse();
      end else begin
        cycle(1'b1, ($urandom_range(99, 0) < 75), ($urandom_range(99, 0) < 25),
              D_W'($urandom), D_W'($urandom));
      end
    end
    repeat (MUL_LAT + 4) cycle(1'b1, 1'b0, 1'b0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
